// File: rtl/branch_predictor.sv
// branch_predictor: 16-entry direct-mapped BTB with 2-bit counters and a
// registered mispredict/redirect pulse.
// The optional BP_STATS_EN macro adds the branch_count and
// mispredict_count statistics outputs.
module branch_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);

  localparam int ENTRIES = 16;

  logic        valid_q [ENTRIES];
  logic [25:0] tag_q   [ENTRIES];
  logic [31:0] tgt_q   [ENTRIES];
  logic [1:0]  ctr_q   [ENTRIES];
  logic        mp_q;
  logic [31:0] redir_q;

  logic [3:0]  f_idx, ex_idx;
  logic        f_hit, ex_hit;
  logic        wr_en, wr_tgt, mp_d;
  logic [1:0]  ctr_d;
  logic [31:0] redir_d;

  // pc[1:0] is always zero for aligned instructions and never indexes the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], ex_pc[1:0]};

  assign f_idx  = f_pc[5:2];
  assign ex_idx = ex_pc[5:2];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed
  always_comb begin
    f_hit       = f_valid & valid_q[f_idx] & (tag_q[f_idx] == f_pc[31:6]);
    pred_taken  = f_hit & ctr_q[f_idx][1];
    pred_target = pred_taken ? tgt_q[f_idx] : f_pc + 32'd4;
  end

  // Resolve-side next state: counter update, allocation and mispredict detection
  always_comb begin
    ex_hit  = valid_q[ex_idx] & (tag_q[ex_idx] == ex_pc[31:6]);
    wr_en   = ex_valid & (ex_hit | ex_taken);
    wr_tgt  = ex_valid & ex_taken;
    ctr_d   = ctr_q[ex_idx];
    if (ex_is_jump)        ctr_d = 2'd3;
    else if (!ex_hit)      ctr_d = 2'd2;
    else if (ex_taken)     ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
    else                   ctr_d = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
    mp_d    = ex_valid & ((ex_taken != ex_pred_taken) |
                          (ex_taken & (ex_target != ex_pred_target)));
    redir_d = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  // Table write: hit updates in place, taken miss allocates over the old occupant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'd1;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_pc[31:6];
      ctr_q[ex_idx]   <= ctr_d;
      if (wr_tgt) tgt_q[ex_idx] <= ex_target;
    end
  end

  // One-cycle redirect pulse; redirect_pc holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_q    <= 1'b0;
      redir_q <= '0;
    end else begin
      mp_q <= mp_d;
      if (mp_d) redir_q <= redir_d;
    end
  end

  assign mispredict  = mp_q;
  assign redirect_pc = redir_q;

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (ex_valid && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mp_d && mp_cnt_q != '1)     mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor; lookup results are checked against a
// small reference table, registered redirect results via an expected-value queue.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];
  logic [31:0] m_redir;
  int unsigned m_br, m_mp;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic mdl_rst();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'd1;
    end
    m_redir = '0; m_br = 0; m_mp = 0;
  endtask

  task automatic mdl_look(input logic v, input logic [31:0] pc,
                          output logic pt, output logic [31:0] tg);
    logic hit;
    hit = v && m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
    pt  = hit && m_ctr[pc[5:2]][1];
    tg  = pt ? m_tgt[pc[5:2]] : pc + 32'd4;
  endtask

  task automatic mdl_upd();
    logic [3:0] i;
    logic hit;
    i   = ex_pc[5:2];
    hit = m_valid[i] && (m_tag[i] == ex_pc[31:6]);
    if (hit) begin
      if (ex_is_jump) m_ctr[i] = 2'd3;
      else if (ex_taken) begin if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1; end
      else if (m_ctr[i] != 2'd0) m_ctr[i] = m_ctr[i] - 2'd1;
      if (ex_taken) m_tgt[i] = ex_target;
    end else if (ex_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = ex_pc[31:6]; m_tgt[i] = ex_target;
      m_ctr[i] = ex_is_jump ? 2'd3 : 2'd2;
    end
  endtask

  // one clock: check lookup before the edge, scoreboard the registered result after
  task automatic cyc();
    logic pt, emp;
    logic [31:0] tg;
    logic [32:0] e;
    #1;
    mdl_look(f_valid, f_pc, pt, tg);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
    chk("pred_target", pred_target, tg);
    emp = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
    if (emp) m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
    sb.push_back({emp, m_redir});
    if (ex_valid) begin
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (emp && m_mp != 32'hFFFF_FFFF) m_mp++;
      mdl_upd();
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("mispredict", {31'd0, mispredict}, {31'd0, e[32]});
    chk("redirect_pc", redirect_pc, e[31:0]);
  endtask

  task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg, input logic jmp);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_pred_taken = ptk; ex_pred_target = ptg; ex_is_jump = jmp;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic ept,
                      input logic [31:0] etg);
    ex_valid = 1'b0; f_valid = 1'b1; f_pc = pc;
    #1;
    chk({tag, "_pt"}, {31'd0, pred_taken}, {31'd0, ept});
    chk({tag, "_tgt"}, pred_target, etg);
    cyc();
  endtask

  initial begin
    logic pt;
    logic [31:0] tg, pc;
    rst = 1'b1; f_valid = 1'b0; f_pc = '0;
    res('0, 1'b0, '0, 1'b0, '0, 1'b0); ex_valid = 1'b0;
    mdl_rst();
    #12;
    chk("rst_mp", {31'd0, mispredict}, 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    @(negedge clk); rst = 1'b0;

    // cold lookup, then a taken branch allocates
    look("cold", 32'h100, 1'b0, 32'h104);
    res(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0); f_valid = 1'b0; cyc();
    chk("alloc_mp", {31'd0, mispredict}, 32'd1);
    chk("alloc_redir", redirect_pc, 32'h200);
    look("alloc_hit", 32'h100, 1'b1, 32'h200);

    // four not-taken resolves: only the first mispredicts
    res(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0); cyc();
    chk("nt1_mp", {31'd0, mispredict}, 32'd1);
    chk("nt1_redir", redirect_pc, 32'h104);
    for (int k = 0; k < 3; k++) begin
      res(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0); cyc();
    end
    look("nt_done", 32'h100, 1'b0, 32'h104);

    // alias at same index evicts
    res(32'h140, 1'b1, 32'h300, 1'b0, 32'h144, 1'b0); cyc();
    look("evicted", 32'h100, 1'b0, 32'h104);
    look("alias_hit", 32'h140, 1'b1, 32'h300);
`ifdef BP_STATS_EN
    chk("stat_br", branch_count, 32'd6);
    chk("stat_mp", mispredict_count, 32'd3);
`endif

    // same-cycle lookup/update of index 0: no bypass
    f_valid = 1'b1; f_pc = 32'h0;
    res(32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    #1; chk("nobyp_tgt", pred_target, 32'h4);
    cyc();
    look("byp_next", 32'h0, 1'b1, 32'h500);

    // back-to-back mispredicts, then hold
    res(32'h20, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0); cyc();
    chk("b2b1_redir", redirect_pc, 32'h700);
    res(32'h24, 1'b0, 32'h0, 1'b1, 32'h999, 1'b0); cyc();
    chk("b2b2_mp", {31'd0, mispredict}, 32'd1);
    chk("b2b2_redir", redirect_pc, 32'h28);
    ex_valid = 1'b0; cyc();
    chk("hold_mp", {31'd0, mispredict}, 32'd0);
    chk("hold_redir", redirect_pc, 32'h28);

    // jump allocates strong-taken; wrong target on a taken hit mispredicts
    res(32'h80, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1); cyc();
    res(32'h80, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0); cyc();
    look("jmp_ctr", 32'h80, 1'b1, 32'h1000);
    res(32'h80, 1'b1, 32'h1200, 1'b1, 32'h1000, 1'b0); cyc();
    chk("tgt_mp", {31'd0, mispredict}, 32'd1);
    chk("tgt_redir", redirect_pc, 32'h1200);
    f_valid = 1'b0; f_pc = 32'h80; ex_valid = 1'b0;
    #1; chk("fv0_pt", {31'd0, pred_taken}, 32'd0);
    chk("fv0_tgt", pred_target, 32'h84);
    cyc();

    // PC wrap
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    res(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h5, 1'b0); cyc();
    chk("wrap_redir", redirect_pc, 32'h0);

    // random traffic over a small PC set to force aliasing and saturation
    for (int k = 0; k < 300; k++) begin
      f_valid = 1'($urandom_range(0, 1));
      f_pc    = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      pc      = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
      res(pc, 1'($urandom_range(0, 1)), {20'd0, 10'($urandom), 2'b00},
          1'b0, 32'h0, 1'($urandom_range(0, 7) == 0));
      ex_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        mdl_look(1'b1, pc, pt, tg);
        ex_pred_taken = pt; ex_pred_target = tg;
        if ($urandom_range(0, 1) == 1) ex_target = tg;
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_target = {20'd0, 10'($urandom), 2'b00};
      end
      cyc();
    end
`ifdef BP_STATS_EN
    chk("rnd_br", branch_count, m_br);
    chk("rnd_mp", mispredict_count, m_mp);
`endif

    // reset in the middle of an update discards it
    res(32'h100, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
    #2; rst = 1'b1;
    #1;
    chk("mrst_mp", {31'd0, mispredict}, 32'd0);
    chk("mrst_redir", redirect_pc, 32'd0);
`ifdef BP_STATS_EN
    chk("mrst_br", branch_count, 32'd0);
    chk("mrst_mpc", mispredict_count, 32'd0);
`endif
    @(posedge clk); @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; mdl_rst();
    look("post_rst", 32'h100, 1'b0, 32'h104);
    look("post_rst_w", 32'hFFFF_FFFC, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
